// File: rtl/board_memory.sv
// rtl/board_memory.sv - Othello board store with datapath/display read ports and live disc counts
// Self-initialises the walled board after reset, then serves 1-cycle reads and guarded writes.
module board_memory #(
  parameter int BOARD_DIM = 10,
  parameter int ADDR_W    = 7,
  parameter int CNT_W     = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_to_mem,
  input  logic [1:0]        data_to_mem,
  input  logic              wren,
  output logic [1:0]        data_get,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [1:0]        disp_data,
  output logic              ready,
  output logic [CNT_W-1:0]  black_count,
  output logic [CNT_W-1:0]  white_count
);

  localparam int CELLS = BOARD_DIM * BOARD_DIM;
  localparam logic [ADDR_W-1:0] DIM_A    = ADDR_W'(BOARD_DIM);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(BOARD_DIM - 1);
  localparam logic [ADDR_W-1:0] MID_A    = ADDR_W'(BOARD_DIM / 2);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_W  = (ADDR_W + 1)'(CELLS);

  localparam logic [1:0] C_NULL  = 2'b00;
  localparam logic [1:0] C_BLACK = 2'b01;
  localparam logic [1:0] C_WHITE = 2'b10;
  localparam logic [1:0] C_WALL  = 2'b11;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ready_q;
  logic [1:0]        data_get_q;
  logic [1:0]        disp_data_q;
  logic [CNT_W-1:0]  black_q;
  logic [CNT_W-1:0]  white_q;
  logic [CNT_W-1:0]  black_d;
  logic [CNT_W-1:0]  white_d;

  logic [1:0]        cells_q [CELLS];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [1:0]        mem_wdata;
  logic [1:0]        cur_cell;
  logic [1:0]        disp_cell;
  logic              wr_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < CELLS_W;
  endfunction

  function automatic logic is_wall(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = a / DIM_A;
    col = a % DIM_A;
    return (row == '0) || (row == LAST_A) || (col == '0) || (col == LAST_A);
  endfunction

  // Starting position: walls on the ring, two white on the diagonal, two black off it.
  function automatic logic [1:0] init_cell(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = a / DIM_A;
    col = a % DIM_A;
    if (is_wall(a))
      return C_WALL;
    else if ((row == MID_A - 1'b1 && col == MID_A - 1'b1) || (row == MID_A && col == MID_A))
      return C_WHITE;
    else if ((row == MID_A - 1'b1 && col == MID_A) || (row == MID_A && col == MID_A - 1'b1))
      return C_BLACK;
    else
      return C_NULL;
  endfunction

  always_comb begin
    cur_cell  = C_WALL;
    disp_cell = C_WALL;
    if (in_range(addr_to_mem)) cur_cell  = cells_q[addr_to_mem];
    if (in_range(disp_addr))   disp_cell = cells_q[disp_addr];

    wr_ok = (state_q == S_READY) && wren && in_range(addr_to_mem) &&
            !is_wall(addr_to_mem) && (data_to_mem != C_WALL);

    mem_we    = 1'b0;
    mem_waddr = addr_to_mem;
    mem_wdata = data_to_mem;
    if (!reset) begin
      if (state_q == S_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = init_cell(ptr_q);
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end

    // Remove the old disc, add the new one; a same-colour write nets to zero.
    black_d = black_q;
    white_d = white_q;
    if (wr_ok) begin
      if (cur_cell == C_BLACK)    black_d = black_d - CNT_W'(1);
      if (cur_cell == C_WHITE)    white_d = white_d - CNT_W'(1);
      if (data_to_mem == C_BLACK) black_d = black_d + CNT_W'(1);
      if (data_to_mem == C_WHITE) white_d = white_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) cells_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      ready_q     <= 1'b0;
      data_get_q  <= C_WALL;
      disp_data_q <= C_WALL;
      black_q     <= '0;
      white_q     <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          data_get_q  <= C_WALL;
          disp_data_q <= C_WALL;
          if (ptr_q == LAST_PTR) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
            black_q <= CNT_W'(2);
            white_q <= CNT_W'(2);
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        S_READY: begin
          data_get_q  <= cur_cell;
          disp_data_q <= disp_cell;
          black_q     <= black_d;
          white_q     <= white_d;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign data_get    = data_get_q;
  assign disp_data   = disp_data_q;
  assign ready       = ready_q;
  assign black_count = black_q;
  assign white_count = white_q;

endmodule

// File: tb/tb_board_memory.sv
// tb/tb_board_memory.sv - directed bench for board_memory
// Reference board model plus a queue of expected read results.
module tb_board_memory;

  localparam int ADDR_W = 7;
  localparam int CNT_W  = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] addr_to_mem = '0;
  logic [1:0]        data_to_mem = '0;
  logic              wren = 1'b0;
  logic [1:0]        data_get;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [1:0]        disp_data;
  logic              ready;
  logic [CNT_W-1:0]  black_count;
  logic [CNT_W-1:0]  white_count;

  board_memory #(.BOARD_DIM(10), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
    .wren(wren), .data_get(data_get), .disp_addr(disp_addr), .disp_data(disp_data),
    .ready(ready), .black_count(black_count), .white_count(white_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] g;
    logic [1:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mb [100];
  int         mblack;
  int         mwhite;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        if (r == 0 || r == 9 || c == 0 || c == 9) mb[r*10+c] = 2'b11;
        else if ((r == 4 && c == 4) || (r == 5 && c == 5)) mb[r*10+c] = 2'b10;
        else if ((r == 4 && c == 5) || (r == 5 && c == 4)) mb[r*10+c] = 2'b01;
        else mb[r*10+c] = 2'b00;
      end
    mblack = 2;
    mwhite = 2;
  endtask

  function automatic logic [1:0] model_rd(input int a);
    return (a >= 100) ? 2'b11 : mb[a];
  endfunction

  task automatic model_wr(input int a, input logic [1:0] d);
    if (a < 100 && mb[a] != 2'b11 && d != 2'b11) begin
      if (mb[a] == 2'b01) mblack--;
      if (mb[a] == 2'b10) mwhite--;
      if (d == 2'b01) mblack++;
      if (d == 2'b10) mwhite++;
      mb[a] = d;
    end
  endtask

  task automatic xfer(input string tag, input int a, input int da, input logic we,
                      input logic [1:0] wd, input logic [1:0] eg, input logic [1:0] ed);
    exp_t e;
    addr_to_mem = ADDR_W'(a);
    disp_addr   = ADDR_W'(da);
    wren        = we;
    data_to_mem = wd;
    sb.push_back('{g: eg, d: ed});
    if (we) model_wr(a, wd);
    @(posedge clock);
    #1;
    wren = 1'b0;
    e = sb.pop_front();
    check({tag, "_get"},   32'(data_get),    32'(e.g));
    check({tag, "_disp"},  32'(disp_data),   32'(e.d));
    check({tag, "_black"}, 32'(black_count), 32'(mblack));
    check({tag, "_white"}, 32'(white_count), 32'(mwhite));
  endtask

  task automatic rd(input string tag, input int a);
    xfer(tag, a, a, 1'b0, 2'b00, model_rd(a), model_rd(a));
  endtask

  task automatic rdk(input string tag, input int a, input logic [1:0] k);
    xfer(tag, a, a, 1'b0, 2'b00, k, k);
  endtask

  task automatic wr(input string tag, input int a, input logic [1:0] d);
    xfer(tag, a, 0, 1'b1, d, model_rd(a), model_rd(0));
  endtask

  task automatic run_reset(input int cut_at);
    reset = 1'b1;
    wren  = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(ready), 0);
    check("rst_get",   32'(data_get), 3);
    check("rst_disp",  32'(disp_data), 3);
    check("rst_black", 32'(black_count), 0);
    check("rst_white", 32'(white_count), 0);
    for (int i = 1; i <= 100; i++) begin
      if (i == 30) begin
        addr_to_mem = 7'd33;
        disp_addr   = 7'd45;
        data_to_mem = 2'b01;
        wren        = 1'b1;
      end
      @(posedge clock);
      #1;
      wren = 1'b0;
      if (i == cut_at) return;
      if (i == 31) begin
        check("init_get",   32'(data_get), 3);
        check("init_disp",  32'(disp_data), 3);
        check("init_black", 32'(black_count), 0);
      end
      if (i == 99) check("ready_99", 32'(ready), 0);
      if (i == 100) begin
        check("ready_100", 32'(ready), 1);
        check("init_black_done", 32'(black_count), 2);
        check("init_white_done", 32'(white_count), 2);
      end
    end
    model_init();
  endtask

  task automatic scenario1();
    rdk("c0", 0, 2'b11);
    rdk("c9", 9, 2'b11);
    rdk("c90", 90, 2'b11);
    rdk("c99", 99, 2'b11);
    rdk("c44", 44, 2'b10);
    rdk("c55", 55, 2'b10);
    rdk("c45", 45, 2'b01);
    rdk("c54", 54, 2'b01);
    rdk("c11", 11, 2'b00);
    rdk("c33", 33, 2'b00);
    check("s1_black", 32'(black_count), 2);
    check("s1_white", 32'(white_count), 2);
  endtask

  initial begin
    run_reset(0);
    scenario1();

    wr("w34", 34, 2'b01);
    rdk("r34", 34, 2'b01);
    check("s2_black", 32'(black_count), 3);
    check("s2_white", 32'(white_count), 2);
    wr("flip44", 44, 2'b01);
    check("flip_black", 32'(black_count), 4);
    check("flip_white", 32'(white_count), 1);

    wr("wall0", 0, 2'b10);
    wr("w23_11", 23, 2'b11);
    wr("w120", 120, 2'b10);
    rdk("r0", 0, 2'b11);
    rdk("r23", 23, 2'b00);
    rdk("r120", 120, 2'b11);
    check("s3_black", 32'(black_count), 4);
    check("s3_white", 32'(white_count), 1);

    xfer("rf33", 33, 33, 1'b1, 2'b10, 2'b00, 2'b00);
    rdk("r33", 33, 2'b10);
    check("s4_white", 32'(white_count), 2);

    for (int i = 0; i < 40; i++)
      wr("rnd_w", int'($urandom_range(0, 110)), 2'($urandom_range(0, 3)));
    for (int a = 0; a < 100; a++)
      xfer("rnd_r", a, 99 - a, 1'b0, 2'b00, model_rd(a), model_rd(99 - a));

    run_reset(50);
    run_reset(0);
    scenario1();
    rdk("r34_clear", 34, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
